// File: rtl/spi_slave_drive.sv
// SPI responder: oversamples the SPI pins in i_clk, decodes {instr, addr} then a write or read payload.
// Optional SPI_SLAVE_ADDR_INC_EN adds o_byte_addr, a per-byte address that follows the payload.
module spi_slave_drive #(
  parameter int         P_DATA_WIDTH = 8,
  parameter int         P_OP_LEN     = 32,
  parameter int         P_CPOL       = 0,
  parameter logic [7:0] P_READ_CMD   = 8'h03,
  parameter int         P_SYNC       = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_spi_clk,
  input  logic                    i_spi_cs,
  input  logic                    i_spi_mosi,
  output logic                    o_spi_miso,
  output logic [P_OP_LEN-1:0]     o_op_data,
  output logic                    o_op_valid,
  output logic [P_DATA_WIDTH-1:0] o_write_data,
  output logic                    o_write_valid,
  output logic                    o_read_req,
  input  logic [P_DATA_WIDTH-1:0] i_read_data,
  output logic                    o_frame_err,
`ifdef SPI_SLAVE_ADDR_INC_EN
  output logic [23:0]             o_byte_addr,
`endif
  output logic                    o_busy
);

  localparam int         BW       = $clog2(P_DATA_WIDTH);
  localparam logic       CLK_IDLE = (P_CPOL != 0);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_HEAD   = 2'd1;
  localparam logic [1:0] S_WR     = 2'd2;
  localparam logic [1:0] S_RD     = 2'd3;

  logic [P_SYNC-1:0] clk_q, cs_q, mosi_q, prime_q;

  // CS resets high and edges are gated until the chain holds only post-reset samples,
  // so a master still mid-frame at reset release cannot fake a CS falling edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      clk_q   <= {P_SYNC{CLK_IDLE}};
      cs_q    <= '1;
      mosi_q  <= '0;
      prime_q <= '0;
    end else begin
      clk_q   <= {clk_q[P_SYNC-2:0], i_spi_clk};
      cs_q    <= {cs_q[P_SYNC-2:0], i_spi_cs};
      mosi_q  <= {mosi_q[P_SYNC-2:0], i_spi_mosi};
      prime_q <= {prime_q[P_SYNC-2:0], 1'b1};
    end
  end

  logic primed, clk_now, clk_prv, cs_now, cs_prv, mosi;
  logic lead, trail, cs_fall, cs_rise;

  assign primed  = prime_q[P_SYNC-1];
  assign clk_now = clk_q[P_SYNC-2];
  assign clk_prv = clk_q[P_SYNC-1];
  assign cs_now  = cs_q[P_SYNC-2];
  assign cs_prv  = cs_q[P_SYNC-1];
  assign mosi    = mosi_q[P_SYNC-1];
  assign lead    = primed & (clk_now != clk_prv) & (clk_now != CLK_IDLE);
  assign trail   = primed & (clk_now != clk_prv) & (clk_now == CLK_IDLE);
  assign cs_fall = primed & cs_prv & ~cs_now;
  assign cs_rise = primed & ~cs_prv & cs_now;
  assign o_busy  = primed & ~cs_now;

  logic [1:0]              state;
  logic [15:0]             cnt, cnt_inc, cnt_aft;
  logic [BW-1:0]           bidx;
  logic [P_OP_LEN-1:0]     hsr, hsr_nx, hsr_aft;
  logic [P_DATA_WIDTH-1:0] bsr, bsr_nx, rsr;
  logic                    rd_ld, hdr_done, byte_done, rd_cmd;

  assign cnt_inc   = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  assign cnt_aft   = lead ? cnt_inc : cnt;
  assign hsr_nx    = {hsr[P_OP_LEN-2:0], mosi};
  assign hsr_aft   = lead ? hsr_nx : hsr;
  assign bsr_nx    = {bsr[P_DATA_WIDTH-2:0], mosi};
  assign rd_cmd    = (hsr_nx[P_OP_LEN-1 -: 8] == P_READ_CMD);
  assign hdr_done  = (state == S_HEAD) & lead & (cnt_inc == 16'(P_OP_LEN));
  assign byte_done = ((state == S_WR) | (state == S_RD)) & lead &
                     (bidx == BW'(P_DATA_WIDTH - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state         <= S_IDLE;
      cnt           <= '0;
      bidx          <= '0;
      hsr           <= '0;
      bsr           <= '0;
      rsr           <= '0;
      rd_ld         <= 1'b0;
      o_spi_miso    <= 1'b0;
      o_op_data     <= '0;
      o_op_valid    <= 1'b0;
      o_write_data  <= '0;
      o_write_valid <= 1'b0;
      o_read_req    <= 1'b0;
      o_frame_err   <= 1'b0;
    end else begin
      o_op_valid    <= 1'b0;
      o_write_valid <= 1'b0;
      o_read_req    <= 1'b0;
      o_frame_err   <= 1'b0;
      rd_ld         <= o_read_req;

      // User byte lands one cycle after the request; it is launched MSB first on trail edges.
      if (rd_ld) rsr <= i_read_data;
      else if (state == S_RD && trail) begin
        o_spi_miso <= rsr[P_DATA_WIDTH-1];
        rsr        <= {rsr[P_DATA_WIDTH-2:0], 1'b0};
      end

      case (state)
        S_IDLE: begin
          if (cs_fall) begin
            state <= S_HEAD;
            cnt   <= '0;
            bidx  <= '0;
          end
        end
        S_HEAD: begin
          if (lead) begin
            hsr <= hsr_nx;
            cnt <= cnt_inc;
          end
          if (hdr_done) begin
            o_op_data  <= hsr_nx;
            o_op_valid <= 1'b1;
            bidx       <= '0;
            if (rd_cmd) begin
              o_read_req <= 1'b1;
              state      <= S_RD;
            end else begin
              state <= S_WR;
            end
          end else if (cs_rise) begin
            // Exactly one instruction byte is a legal short frame; anything else aborts.
            if (cnt_aft == 16'd8) begin
              o_op_data  <= {hsr_aft[7:0], {(P_OP_LEN-8){1'b0}}};
              o_op_valid <= 1'b1;
            end else begin
              o_frame_err <= 1'b1;
            end
          end
          if (cs_rise) state <= S_IDLE;
        end
        default: begin
          if (lead) begin
            bsr  <= bsr_nx;
            cnt  <= cnt_inc;
            bidx <= byte_done ? '0 : bidx + 1'b1;
          end
          if (byte_done) begin
            if (state == S_WR) begin
              o_write_data  <= bsr_nx;
              o_write_valid <= 1'b1;
            end else begin
              o_read_req <= 1'b1;
            end
          end
          if (cs_rise) state <= S_IDLE;
        end
      endcase

      if (cs_rise) o_spi_miso <= 1'b0;
    end
  end

`ifdef SPI_SLAVE_ADDR_INC_EN
  logic addr_inc;

  // Step one cycle after a completed byte so the address shown with a byte is its own.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_byte_addr <= '0;
      addr_inc    <= 1'b0;
    end else begin
      addr_inc <= byte_done;
      if (hdr_done) o_byte_addr <= hsr_nx[23:0];
      else if (state == S_HEAD && cs_rise) o_byte_addr <= '0;
      else if (addr_inc) o_byte_addr <= o_byte_addr + 24'd1;
    end
  end
`endif

endmodule

// File: tb/tb_spi_slave_drive.sv
// Scoreboard bench for spi_slave_drive: a mode-0 master task drives frames, a reference model
// queues expected events, and a negedge monitor pops and compares as the DUT emits them.
module tb_spi_slave_drive;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_spi_clk = 1'b0;
  logic        i_spi_cs = 1'b1;
  logic        i_spi_mosi = 1'b0;
  logic [7:0]  i_read_data = 8'h00;
  logic        o_spi_miso, o_op_valid, o_write_valid, o_read_req, o_frame_err, o_busy;
  logic [31:0] o_op_data;
  logic [7:0]  o_write_data;
`ifdef SPI_SLAVE_ADDR_INC_EN
  logic [23:0] o_byte_addr;
`endif

  spi_slave_drive dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_spi_clk    (i_spi_clk),
    .i_spi_cs     (i_spi_cs),
    .i_spi_mosi   (i_spi_mosi),
    .o_spi_miso   (o_spi_miso),
    .o_op_data    (o_op_data),
    .o_op_valid   (o_op_valid),
    .o_write_data (o_write_data),
    .o_write_valid(o_write_valid),
    .o_read_req   (o_read_req),
    .i_read_data  (i_read_data),
    .o_frame_err  (o_frame_err),
`ifdef SPI_SLAVE_ADDR_INC_EN
    .o_byte_addr  (o_byte_addr),
`endif
    .o_busy       (o_busy)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int fails  = 0;

  logic [31:0] exp_op[$];
  logic [7:0]  exp_wr[$];
  logic [7:0]  rd_user[$];
  logic [7:0]  pay[$];
  bit          fbits[$];
  bit          miso_got[$];
  int          req_cnt = 0;
  int          err_seen = 0;
  int          ev_cnt = 0;
  logic [31:0] mon_op;
  logic [7:0]  mon_wr;
  logic [23:0] cur_addr = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    fails++;
    $display("FAIL %s actual=pulse required=none", name);
  endtask

  // Monitor: pops expectations as the DUT produces events and feeds read bytes on request.
  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (o_op_valid) begin
        ev_cnt++;
        if (exp_op.size() == 0) unexpected("op_valid");
        else begin
          mon_op = exp_op.pop_front();
          chk("op_data", 64'(o_op_data), 64'(mon_op));
`ifdef SPI_SLAVE_ADDR_INC_EN
          chk("byte_addr_op", 64'(o_byte_addr), 64'(mon_op[23:0]));
          cur_addr = mon_op[23:0];
`endif
        end
      end
      if (o_write_valid) begin
        ev_cnt++;
        if (exp_wr.size() == 0) unexpected("write_valid");
        else begin
          mon_wr = exp_wr.pop_front();
          chk("write_data", 64'(o_write_data), 64'(mon_wr));
`ifdef SPI_SLAVE_ADDR_INC_EN
          chk("byte_addr_wr", 64'(o_byte_addr), 64'(cur_addr));
          cur_addr = cur_addr + 24'd1;
`endif
        end
      end
      if (o_frame_err) begin
        ev_cnt++;
        err_seen++;
      end
      if (o_read_req) begin
        ev_cnt++;
        req_cnt++;
        i_read_data = (rd_user.size() != 0) ? rd_user.pop_front() : 8'h00;
      end
    end
  end

  // Mode-0 master: 8 system clocks per SPI half period; MISO sampled at each rising edge.
  task automatic spi_xfer();
    miso_got.delete();
    i_spi_cs = 1'b0;
    repeat (8) @(negedge i_clk);
    foreach (fbits[i]) begin
      i_spi_mosi = fbits[i];
      repeat (8) @(negedge i_clk);
      miso_got.push_back(o_spi_miso);
      i_spi_clk = 1'b1;
      repeat (8) @(negedge i_clk);
      i_spi_clk = 1'b0;
    end
    repeat (8) @(negedge i_clk);
    i_spi_cs = 1'b1;
    repeat (8) @(negedge i_clk);
  endtask

  // Reference model: hb header bits of hdr are sent, then pb payload bits drawn from pay.
  task automatic run_frame(input string tag, input int hb, input logic [31:0] hdr, input int pb);
    bit          is_rd;
    int          exp_req, exp_err;
    logic [7:0]  b;
    logic [63:0] gv, ev;
    is_rd   = (hb == 32) && (hdr[31:24] == 8'h03);
    exp_req = 0;
    exp_err = 0;
    fbits.delete();
    for (int i = 0; i < hb; i++) fbits.push_back(hdr[31-i]);
    if (hb == 32) begin
      exp_op.push_back(hdr);
      if (is_rd) begin
        exp_req = 1 + pb / 8;
        rd_user.delete();
        foreach (pay[k]) rd_user.push_back(pay[k]);
      end else begin
        for (int k = 0; k < pb / 8; k++) exp_wr.push_back(pay[k]);
      end
    end else if (hb == 8) begin
      exp_op.push_back({hdr[31:24], 24'h0});
    end else begin
      exp_err = 1;
    end
    for (int j = 0; j < pb; j++) begin
      b = pay[j/8];
      fbits.push_back(is_rd ? bit'($urandom_range(0, 1)) : b[7-(j%8)]);
    end
    req_cnt  = 0;
    err_seen = 0;
    spi_xfer();
    repeat (20) @(negedge i_clk);
    chk({tag, "_read_req_count"}, 64'(req_cnt), 64'(exp_req));
    chk({tag, "_frame_err_count"}, 64'(err_seen), 64'(exp_err));
    chk({tag, "_pending_events"}, 64'(exp_op.size() + exp_wr.size()), 64'd0);
    chk({tag, "_busy_after"}, 64'(o_busy), 64'd0);
    if (is_rd && pb > 0) begin
      gv = '0;
      ev = '0;
      for (int j = 0; j < pb; j++) begin
        b  = pay[j/8];
        gv = {gv[62:0], miso_got[hb+j]};
        ev = {ev[62:0], b[7-(j%8)]};
      end
      chk({tag, "_miso_bits"}, gv, ev);
    end
    exp_op.delete();
    exp_wr.delete();
    rd_user.delete();
  endtask

  task automatic rand_pay(input int nbytes);
    pay.delete();
    for (int k = 0; k < nbytes; k++) pay.push_back(8'($urandom));
  endtask

  initial begin
    #5000000;
    checks++;
    fails++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    int          hb, pb;
    logic [31:0] hdr;
    int          ev_snap;

    repeat (3) @(negedge i_clk);
    chk("reset_outputs", {o_op_valid, o_write_valid, o_read_req, o_frame_err, o_busy, o_spi_miso},
        64'd0);
    chk("reset_op_data", 64'(o_op_data), 64'd0);
    i_rst = 1'b0;
    repeat (5) @(negedge i_clk);

    pay = '{8'hA5, 8'h3C};
    run_frame("t1_write", 32, 32'h02001000, 16);
    pay = '{8'h5A, 8'hC3, 8'h77};
    run_frame("t2_read", 32, 32'h03000010, 16);
    pay.delete();
    run_frame("t3_instr_only", 8, 32'h06ABCDEF, 0);
    run_frame("t4_short_head", 13, 32'h0B123456, 0);
    pay = '{8'h11, 8'h22};
    run_frame("t4_next_frame", 32, 32'h02345678, 16);
    pay = '{8'h9E};
    run_frame("t5_partial", 32, 32'h02000040, 4);
    pay = '{8'h12, 8'h34};
    run_frame("t6_addr_wrap", 32, 32'h02FFFFFF, 16);

    // Reset in the middle of the second read byte: nothing after reset may produce events.
    rand_pay(3);
    hdr = {8'h03, 24'($urandom)};
    exp_op.push_back(hdr);
    rd_user.delete();
    foreach (pay[k]) rd_user.push_back(pay[k]);
    fbits.delete();
    for (int i = 0; i < 32; i++) fbits.push_back(hdr[31-i]);
    for (int j = 0; j < 24; j++) fbits.push_back(bit'($urandom_range(0, 1)));
    req_cnt = 0;
    ev_snap = 0;
    fork
      spi_xfer();
      begin
        repeat (8 + 44 * 16) @(negedge i_clk);
        i_rst = 1'b1;
        #1;
        chk("t6_rst_outputs",
            {o_op_valid, o_write_valid, o_read_req, o_frame_err, o_busy, o_spi_miso}, 64'd0);
        chk("t6_rst_op_data", 64'(o_op_data), 64'd0);
        repeat (3) @(negedge i_clk);
        i_rst = 1'b0;
        ev_snap = ev_cnt;
      end
    join
    repeat (20) @(negedge i_clk);
    chk("t6_req_before_rst", 64'(req_cnt), 64'd2);
    chk("t6_events_after_rst", 64'(ev_cnt - ev_snap), 64'd0);
    chk("t6_pending", 64'(exp_op.size()), 64'd0);
    rd_user.delete();
    pay = '{8'hC0, 8'hDE};
    run_frame("t6_recover", 32, 32'h02000100, 16);

    for (int n = 0; n < 18; n++) begin
      hdr = 32'($urandom);
      case ($urandom_range(0, 9))
        0: begin hb = $urandom_range(1, 31); if (hb == 8) hb = 9; end
        1: hb = 8;
        default: hb = 32;
      endcase
      if ($urandom_range(0, 1) == 1) hdr[31:24] = 8'h03;
      else if (hdr[31:24] == 8'h03) hdr[31:24] = 8'h02;
      pb = (hb == 32) ? int'($urandom_range(0, 40)) : 0;
      rand_pay(1 + pb / 8);
      run_frame("rand", hb, hdr, pb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
